// File: rtl/if_prefetch_buffer_if.sv
// Instruction-side bus: request/grant address phase plus rvalid response phase.
interface if_prefetch_buffer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] addr;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    // Fetch unit side
    modport master (
        output req, addr,
        input  gnt, rvalid, rdata, err
    );

    // Memory / interconnect side
    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: keeps up to MAX_OUTSTANDING pipelined bus requests in flight,
// buffers returned words in a DEPTH-entry FIFO and flushes on redirect.
module if_prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_W-1:0]    boot_addr_i,
    input  logic                 fetch_en_i,
    input  logic                 branch_i,
    input  logic [ADDR_W-1:0]    branch_addr_i,
    output logic                 fetch_valid_o,
    input  logic                 fetch_ready_i,
    output logic [DATA_W-1:0]    fetch_rdata_o,
    output logic [ADDR_W-1:0]    fetch_addr_o,
    output logic                 fetch_err_o,
    output logic                 busy_o,
    if_prefetch_buffer_if.master instr
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DW = $clog2(MAX_OUTSTANDING + 2);

    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] first_addr_q, first_addr_d;
    logic              first_pend_q, first_pend_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic              stale_q, stale_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [DW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic              err_mem  [DEPTH];

    logic              gnt_acc, rsp_acc, drop, push, pop, pending_after;
    logic [ADDR_W-1:0] branch_word;
    logic [ADDR_W-1:0] entry_addr;

    assign branch_word = {branch_addr_i[ADDR_W-1:2], 2'b00};
    assign entry_addr  = first_pend_q ? first_addr_q : resp_addr_q;

    // Next-state for bus accounting, FIFO pointers and request issue
    always_comb begin
        gnt_acc       = req_q && instr.gnt;
        // Responses with nothing outstanding (e.g. left over from before reset) are ignored
        rsp_acc       = instr.rvalid && (outstanding_q != '0);
        drop          = rsp_acc && (discard_q != '0);
        push          = rsp_acc && !drop && !branch_i;
        pop           = (count_q != '0) && fetch_ready_i && !branch_i;
        pending_after = req_q && !instr.gnt;

        outstanding_d = outstanding_q + OW'(gnt_acc) - OW'(rsp_acc);

        discard_d     = discard_q;
        stale_d       = stale_q;
        fetch_addr_d  = fetch_addr_q;
        first_addr_d  = first_addr_q;
        first_pend_d  = first_pend_q;
        resp_addr_d   = resp_addr_q;
        count_d       = count_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;

        if (branch_i) begin
            // Everything still in flight, including an ungranted request, belongs to the old path
            discard_d    = DW'(outstanding_d) + DW'(pending_after);
            stale_d      = pending_after;
            fetch_addr_d = branch_word;
            first_addr_d = branch_addr_i;
            first_pend_d = 1'b1;
            resp_addr_d  = branch_word;
            count_d      = '0;
            wptr_d       = '0;
            rptr_d       = '0;
        end else begin
            if (drop) discard_d = discard_q - DW'(1);
            if (gnt_acc) begin
                stale_d = 1'b0;
                // A stale request's grant must not advance the redirected fetch address
                if (!stale_q) fetch_addr_d = fetch_addr_q + ADDR_W'(4);
            end
            if (push) begin
                first_pend_d = 1'b0;
                resp_addr_d  = resp_addr_q + ADDR_W'(4);
                wptr_d       = wptr_q + PW'(1);
            end
            if (pop) rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // Requests are never retracted; new ones reserve FIFO space for their response
        if (pending_after) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = fetch_en_i && !branch_i
                     && (32'(outstanding_d) < MAX_OUTSTANDING)
                     && ((32'(count_d) + 32'(outstanding_d)) < DEPTH);
            addr_d = req_d ? fetch_addr_d : addr_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_q         <= 1'b0;
            addr_q        <= '0;
            fetch_addr_q  <= {boot_addr_i[ADDR_W-1:2], 2'b00};
            first_addr_q  <= boot_addr_i;
            first_pend_q  <= 1'b1;
            resp_addr_q   <= {boot_addr_i[ADDR_W-1:2], 2'b00};
            stale_q       <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            req_q         <= req_d;
            addr_q        <= addr_d;
            fetch_addr_q  <= fetch_addr_d;
            first_addr_q  <= first_addr_d;
            first_pend_q  <= first_pend_d;
            resp_addr_q   <= resp_addr_d;
            stale_q       <= stale_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
        end
    end

    // FIFO storage; contents are don't-care while count is zero
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            data_mem[wptr_q] <= instr.rdata;
            addr_mem[wptr_q] <= entry_addr;
            err_mem[wptr_q]  <= instr.err;
        end
    end

    assign instr.req     = req_q;
    assign instr.addr    = addr_q;
    assign fetch_valid_o = (count_q != '0);
    assign fetch_rdata_o = fetch_valid_o ? data_mem[rptr_q] : '0;
    assign fetch_addr_o  = fetch_valid_o ? addr_mem[rptr_q] : '0;
    assign fetch_err_o   = fetch_valid_o && err_mem[rptr_q];
    assign busy_o        = req_q || (outstanding_q != '0);
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Scoreboard bench for if_prefetch_buffer: directed bursts, back-pressure, stalled grant,
// redirects and mid-burst reset against a simple OBI memory model.
module tb_if_prefetch_buffer;
    logic        CLK;
    logic        RST;
    logic [31:0] boot_addr;
    logic        fetch_en;
    logic        branch_s;
    logic [31:0] branch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic [31:0] fetch_addr;
    logic        fetch_err;
    logic        busy;

    logic        gnt_en;
    logic        rsp_en;
    logic [31:0] err_addr;
    int          gnt_cnt;
    int          n_vec;
    int          n_miss;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rsp_q[$];

    if_prefetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_prefetch_buffer #(
        .DEPTH(4), .MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .boot_addr_i   (boot_addr),
        .fetch_en_i    (fetch_en),
        .branch_i      (branch_s),
        .branch_addr_i (branch_addr),
        .fetch_valid_o (fetch_valid),
        .fetch_ready_i (fetch_ready),
        .fetch_rdata_o (fetch_rdata),
        .fetch_addr_o  (fetch_addr),
        .fetch_err_o   (fetch_err),
        .busy_o        (busy),
        .instr         (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: grant is combinational, response follows one cycle later in order
    assign bus.gnt = bus.req && gnt_en;

    initial begin
        logic        cap;
        logic        en;
        logic [31:0] a;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        bus.err    = 1'b0;
        forever begin
            @(posedge CLK);
            cap = bus.req && bus.gnt;
            en  = rsp_en;
            a   = bus.addr;
            if (cap) begin
                rsp_q.push_back(a);
                gnt_cnt++;
            end
            #1;
            if (en && rsp_q.size() > 0) begin
                a          = rsp_q.pop_front();
                bus.rvalid = 1'b1;
                bus.rdata  = word_of(a);
                bus.err    = (a == err_addr);
            end else begin
                bus.rvalid = 1'b0;
                bus.rdata  = '0;
                bus.err    = 1'b0;
            end
        end
    end

    // Monitor: every accepted head entry must match the next expected entry
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && !branch_s && fetch_valid && fetch_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL pop_unexpected: got addr %h data %h err %b, required no entry",
                         fetch_addr, fetch_rdata, fetch_err);
            end else begin
                e = exp_q.pop_front();
                if (fetch_addr !== e.addr || fetch_rdata !== e.data || fetch_err !== e.err) begin
                    n_miss++;
                    $display("FAIL pop_entry: got addr %h data %h err %b, required %h %h %b",
                             fetch_addr, fetch_rdata, fetch_err, e.addr, e.data, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", nm, act, expv);
        end
    endtask

    task automatic exp_push(input logic [31:0] ea, input logic [31:0] wa, input logic er);
        exp_t e;
        e.addr = ea;
        e.data = word_of(wa);
        e.err  = er;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_rdata"}, fetch_rdata, 32'd0);
        chk({tag, "_faddr"}, fetch_addr, 32'd0);
        chk({tag, "_ferr"},  32'(fetch_err), 32'd0);
        chk({tag, "_req"},   32'(bus.req), 32'd0);
        chk({tag, "_iaddr"}, bus.addr, 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        bit seen;
        n_vec = 0; n_miss = 0; gnt_cnt = 0;
        RST = 1'b1; boot_addr = 32'h80; fetch_en = 1'b0; branch_s = 1'b0;
        branch_addr = '0; fetch_ready = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
        err_addr = 32'hFFFF_FFFF;
        tick(); tick();
        chk_reset_outputs("reset");

        // Zero-wait burst of three words from boot address
        RST = 1'b0; fetch_en = 1'b1; exp_push(32'h80, 32'h80, 1'b0);
        exp_push(32'h84, 32'h84, 1'b0); exp_push(32'h88, 32'h88, 1'b0);
        tick(); chk("burst_req0", 32'(bus.req), 32'd1); chk("burst_addr0", bus.addr, 32'h80);
        tick(); chk("burst_addr1", bus.addr, 32'h84); chk("burst_valid_early", 32'(fetch_valid), 0);
        tick(); chk("burst_addr2", bus.addr, 32'h88); chk("burst_valid_first", 32'(fetch_valid), 1);
        chk("burst_head_addr", fetch_addr, 32'h80); fetch_en = 1'b0;
        tick(); chk("burst_req_stop", 32'(bus.req), 32'd0);
        repeat (5) tick();
        chk("burst_drained", 32'(exp_q.size()), 0); chk("burst_busy_idle", 32'(busy), 0);

        // Back-pressure: exactly DEPTH grants, then one pop frees one request
        fetch_ready = 1'b0; fetch_en = 1'b1; base = gnt_cnt;
        for (int i = 0; i < 4; i++) exp_push(32'h8C + 32'(4 * i), 32'h8C + 32'(4 * i), 1'b0);
        exp_push(32'h9C, 32'h9C, 1'b0);
        repeat (10) tick();
        chk("full_grants", 32'(gnt_cnt - base), 32'd4); chk("full_req", 32'(bus.req), 0);
        chk("full_valid", 32'(fetch_valid), 1); chk("full_head", fetch_addr, 32'h8C);
        base = gnt_cnt; fetch_ready = 1'b1;
        tick(); fetch_ready = 1'b0;
        repeat (6) tick();
        chk("pop_one_grant", 32'(gnt_cnt - base), 32'd1); chk("pop_one_req", 32'(bus.req), 0);
        fetch_en = 1'b0; fetch_ready = 1'b1;
        repeat (8) tick();
        chk("full_drained", 32'(exp_q.size()), 0);

        // Grant withheld three cycles: request and address must hold
        RST = 1'b1; boot_addr = 32'h80; exp_q.delete();
        tick(); RST = 1'b0; fetch_en = 1'b1;
        exp_push(32'h80, 32'h80, 1'b0); exp_push(32'h84, 32'h84, 1'b0);
        tick(); chk("hold_addr0", bus.addr, 32'h80);
        tick(); gnt_en = 1'b0; chk("hold_req_c1", 32'(bus.req), 1); chk("hold_addr_c1", bus.addr, 32'h84);
        tick(); fetch_en = 1'b0; chk("hold_req_c2", 32'(bus.req), 1); chk("hold_addr_c2", bus.addr, 32'h84);
        tick(); chk("hold_req_c3", 32'(bus.req), 1); chk("hold_addr_c3", bus.addr, 32'h84);
        tick(); gnt_en = 1'b1; chk("hold_addr_c4", bus.addr, 32'h84);
        tick(); chk("hold_req_released", 32'(bus.req), 0);
        repeat (6) tick();
        chk("hold_drained", 32'(exp_q.size()), 0);

        // Redirect to unaligned target with two responses in flight
        rsp_en = 1'b0; fetch_en = 1'b1;
        exp_push(32'h202, 32'h200, 1'b0); exp_push(32'h204, 32'h204, 1'b0);
        tick(); chk("redir_addr0", bus.addr, 32'h88);
        tick(); chk("redir_addr1", bus.addr, 32'h8C);
        tick(); chk("redir_req_cap", 32'(bus.req), 0);
        branch_s = 1'b1; branch_addr = 32'h202;
        tick(); branch_s = 1'b0; rsp_en = 1'b1;
        chk("redir_valid_after", 32'(fetch_valid), 0); chk("redir_busy", 32'(busy), 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.req) begin seen = 1'b1; break; end
            tick();
        end
        chk("redir_req_seen", 32'(seen), 1); chk("redir_new_addr", bus.addr, 32'h200);
        tick(); chk("redir_next_addr", bus.addr, 32'h204); fetch_en = 1'b0;
        repeat (6) tick();
        chk("redir_drained", 32'(exp_q.size()), 0);

        // Redirect coinciding with rvalid and a fresh grant
        fetch_en = 1'b1;
        tick(); chk("coin_addr0", bus.addr, 32'h208);
        tick(); chk("coin_addr1", bus.addr, 32'h20C);
        branch_s = 1'b1; branch_addr = 32'h300; fetch_en = 1'b0;
        tick(); branch_s = 1'b0; chk("coin_valid_c1", 32'(fetch_valid), 0);
        tick(); chk("coin_valid_c2", 32'(fetch_valid), 0); chk("coin_busy", 32'(busy), 0);
        fetch_en = 1'b1; exp_push(32'h300, 32'h300, 1'b0);
        tick(); chk("coin_restart_addr", bus.addr, 32'h300); fetch_en = 1'b0;
        repeat (6) tick();
        chk("coin_drained", 32'(exp_q.size()), 0);

        // Bus error on the second response of a burst
        err_addr = 32'h308; fetch_en = 1'b1;
        exp_push(32'h304, 32'h304, 1'b0); exp_push(32'h308, 32'h308, 1'b1);
        exp_push(32'h30C, 32'h30C, 1'b0);
        tick(); tick(); tick(); fetch_en = 1'b0;
        repeat (6) tick();
        chk("err_drained", 32'(exp_q.size()), 0);

        // Reset in the middle of a burst
        err_addr = 32'hFFFF_FFFF; fetch_en = 1'b1;
        tick(); chk("mid_addr0", bus.addr, 32'h310);
        tick(); RST = 1'b1; boot_addr = 32'h400; fetch_en = 1'b0;
        tick(); chk_reset_outputs("midrst");
        exp_q.delete(); RST = 1'b0; fetch_en = 1'b1; exp_push(32'h400, 32'h400, 1'b0);
        tick(); chk("midrst_req", 32'(bus.req), 1); chk("midrst_addr", bus.addr, 32'h400);
        fetch_en = 1'b0;
        repeat (6) tick();
        chk("midrst_drained", 32'(exp_q.size()), 0);
        chk("final_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
